uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver. Successor to the fixed 8N1 mid-bit receiver.
- Adds configurable data width, stop bits and parity, plus an oversampled majority-vote bit decision and a false-start reject.
- Exposes a valid/ready output with error flags and overrun reporting.
- Sits between the board RX pin and byte consumers (LCD text loader, command parser).

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz
- BAUD_RATE, 9600, line rate in baud
- OVERSAMPLE, 16, samples per bit; must be even and >= 8
- DATA_BITS, 8, data bits per frame, 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received word, LSB = first bit on the line
- rx_valid  out  1  rx_data, rx_perr and rx_ferr are valid
- rx_ready  in  1  consumer accepts the word
- rx_perr  out  1  parity error on the held word
- rx_ferr  out  1  stop-bit (framing) error on the held word
- rx_overrun  out  1  one-cycle pulse: a frame was dropped
- rx_busy  out  1  state != RX_IDLE

Behaviour:
- Reset: all outputs 0 except rx_data = 0. Synchroniser flops = 1, state = RX_IDLE, counters = 0. Reset mid-frame abandons the frame with no output.
- Input path: rx passes through a 2-flop synchroniser, then a 3-deep shift register of tick samples.
- Sample tick: 1-cycle strobe every OS_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer truncation). Default OS_DIV = 325.
  - The tick counter free-runs.
  - It is cleared on the IDLE->START transition, so sampling phase is aligned to the start edge.
- os_cnt counts ticks 0..OVERSAMPLE-1 inside each bit. The bit decision is the majority of the 3 samples taken at ticks MID-1, MID and MID+1, where MID = OVERSAMPLE/2. The decision is made on tick MID+1.
- States (shared enum): RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP.
  - RX_IDLE: synchronised rx 1->0 -> RX_START.
  - RX_START: decision 1 -> RX_IDLE (false start, no output). Decision 0 -> RX_DATA at os_cnt wrap.
  - RX_DATA: shift the decision into the MSB of the shift register (LSB-first line order). After DATA_BITS bits -> RX_PARITY if PARITY_MODE != 0, else RX_STOP.
  - RX_PARITY: the decision is XORed with the data XOR; a mismatch against the mode sets perr. -> RX_STOP.
  - RX_STOP: a decision of 0 on any stop bit sets ferr.
    - After the last stop bit's decision (not at bit end), go to RX_IDLE, so a following start edge is caught with half a bit of margin.
- Output register, loaded on the cycle after the final stop decision:
  - If rx_valid = 0 or rx_ready = 1 that cycle: load rx_data, rx_perr and rx_ferr; rx_valid <= 1.
  - Else: keep the held word, drop the new one, pulse rx_overrun for 1 cycle.
- Handshake:
  - rx_valid, rx_data and the flags are stable until rx_valid && rx_ready.
  - On that cycle rx_valid <= 0, unless a new word loads the same cycle (then it stays 1 with the new data).
- Error frames are delivered, not discarded. The consumer decides.
- Parity bit is ignored entirely when PARITY_MODE = 0.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined: a frame with all data bits 0, parity bit (if any) 0 and first stop bit 0 is a break condition.
  - No word is loaded and rx_break (extra 1-bit output, reset 0) pulses for 1 cycle.
  - FSM holds in RX_STOP until synchronised rx = 1 for one full bit time, then goes to RX_IDLE.
- Undefined: no rx_break port. Such a frame is delivered as rx_data = 0 with rx_ferr = 1, and the FSM returns to RX_IDLE normally.

Decomposition:
- Shared package:
  - Extended rx_state enum (adds RX_PARITY).
  - PARITY_NONE/EVEN/ODD localparams.
  - Default CLK_FREQ, BAUD_RATE and OVERSAMPLE values.
  - OS_DIV computed as a package function of the three parameters.
- Sub-module uart_os_tick: parametrised divider producing the tick strobe, with a synchronous clear input. Reusable by a future TX block.

Test Plan:
- 8N1 at 9600, rx_ready tied 1: send 0xA5 -> rx_valid pulses once, rx_data = 0xA5, perr = ferr = 0. Pulse comes ~9.5 bit times after the start edge.
- PARITY_MODE = 1 (even), send 0x07 with parity bit 0 -> rx_perr = 1, rx_data = 0x07. Same word with parity 1 -> rx_perr = 0.
- rx_ready held 0, send 0x11 then 0x22 -> rx_data stays 0x11, one rx_overrun pulse. Raise rx_ready -> valid drops the next cycle.
- Glitch: rx low for 3 ticks only -> returns to RX_IDLE, no rx_valid, rx_busy low again within 1 bit time.
- Stop bit forced 0 on 0x3C; then, with the macro defined, hold rx low for 2 frame times -> first case gives rx_ferr = 1 with data 0x3C. Second case gives one rx_break pulse and no rx_valid.
- Deassert rst_n during RX_DATA of 0x55 -> all outputs 0 immediately. A following clean 0x66 is received correctly.

Source files
------------

// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os shared types and constants.
// Frame states, parity modes, default rates and the tick divider.
package uart_rx_os_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int DEF_OVERSAMPLE = 16;

  function automatic int os_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: 1-cycle strobe every DIV clocks.
// clr restarts the count so the phase follows the caller.
module uart_os_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // free-running divider, synchronously restartable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote and false-start reject.
// Optional break detect: define UART_RX_BREAK_DET_EN.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 rx_break,
`endif
  output logic                 rx_busy
);

  localparam int DIV = os_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_DEC  = OSW'(MID + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [3:0] BITS_N = 4'(DATA_BITS);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_t state, state_d;

  logic s1, s2, rx_prev;
  logic rx_s, fall;
  logic [2:0] samp;
  logic vote, tick, clr;
  logic dec, fin, wrap;
  logic frame_end, brk_now;
  logic last_stop, par_x, os_hold_rst;
  logic [OSW-1:0] os_cnt;
  logic [3:0] bit_cnt;
  logic stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic perr_f, ferr_f;

`ifdef UART_RX_BREAK_DET_EN
  logic brk_hold, par_bit, is_brk;
`endif

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  assign rx_s = s2;
  assign fall = rx_prev & ~rx_s;
  assign vote = (samp[2] & samp[1]) |
                (samp[2] & samp[0]) |
                (samp[1] & samp[0]);
  assign wrap = tick && (os_cnt == OS_LAST);
  assign last_stop = (stop_cnt == STOP_LAST);
  assign par_x = vote ^ (^shreg);
  assign rx_busy = (state != RX_IDLE);

`ifdef UART_RX_BREAK_DET_EN
  assign is_brk = !stop_cnt && !vote &&
                  (shreg == '0) &&
                  ((PARITY_MODE == PARITY_NONE) || !par_bit);
  assign os_hold_rst = brk_hold && !rx_s;
`else
  assign os_hold_rst = 1'b0;
`endif

  // synchroniser, edge history and tick-sample window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      rx_prev <= 1'b1;
      samp    <= 3'b111;
    end else begin
      s1      <= rx;
      s2      <= s1;
      rx_prev <= s2;
      if (tick)
        samp <= {samp[1:0], rx_s};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RX_IDLE;
    else
      state <= state_d;
  end

  // next state and frame control strobes
  always_comb begin
    state_d   = state;
    clr       = 1'b0;
    frame_end = 1'b0;
    brk_now   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          clr     = 1'b1;
        end
      end
      RX_START: begin
        if (dec && vote)
          state_d = RX_IDLE;
        else if (wrap)
          state_d = RX_DATA;
      end
      RX_DATA: begin
        if (wrap && bit_cnt == BITS_N)
          state_d = (PARITY_MODE != PARITY_NONE) ?
                    RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (wrap)
          state_d = RX_STOP;
      end
      RX_STOP: begin
`ifdef UART_RX_BREAK_DET_EN
        if (brk_hold) begin
          if (tick && rx_s && os_cnt == OS_LAST)
            state_d = RX_IDLE;
        end else if (dec && is_brk) begin
          brk_now = 1'b1;
        end else if (dec && last_stop) begin
          frame_end = 1'b1;
          state_d   = RX_IDLE;
        end
`else
        if (dec && last_stop) begin
          frame_end = 1'b1;
          state_d   = RX_IDLE;
        end
`endif
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // bit timing, data shift and per-frame error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr_f   <= 1'b0;
      ferr_f   <= 1'b0;
      dec      <= 1'b0;
      fin      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_hold <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      dec <= tick && (os_cnt == OS_DEC) &&
             (state != RX_IDLE);
      fin <= frame_end;
      if (clr) begin
        os_cnt   <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr_f   <= 1'b0;
        ferr_f   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_hold <= 1'b0;
        par_bit  <= 1'b0;
`endif
      end else begin
        if (tick && state != RX_IDLE) begin
          if (os_cnt == OS_LAST || os_hold_rst)
            os_cnt <= '0;
          else
            os_cnt <= os_cnt + 1'b1;
        end
`ifdef UART_RX_BREAK_DET_EN
        if (brk_now) begin
          os_cnt   <= '0;
          brk_hold <= 1'b1;
        end
`endif
        if (dec && state == RX_DATA) begin
          shreg   <= {vote, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (dec && state == RX_PARITY) begin
          perr_f <= (PARITY_MODE == PARITY_ODD) ?
                    ~par_x : par_x;
`ifdef UART_RX_BREAK_DET_EN
          par_bit <= vote;
`endif
        end
`ifdef UART_RX_BREAK_DET_EN
        if (dec && state == RX_STOP && !brk_hold) begin
`else
        if (dec && state == RX_STOP) begin
`endif
          if (!vote)
            ferr_f <= 1'b1;
          stop_cnt <= stop_cnt + 1'b1;
        end
      end
    end
  end

  // output word register with handshake and overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (fin) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_perr  <= perr_f;
          rx_ferr  <= ferr_f;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // one-cycle break indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rx_break <= 1'b0;
    else
      rx_break <= brk_now;
  end
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os, 8E1 at a scaled clock.
// Random frames checked against a frame-level model.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1_280_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIV * OS;
  localparam int MID      = OS / 2;
  localparam int LAT_LO   = (10 * OS + MID) * DIV;
  localparam int LAT_HI   = (10 * OS + MID + 2) * DIV + 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_perr, rx_ferr;
  logic rx_overrun, rx_busy;
`ifdef UART_RX_BREAK_DET_EN
  logic rx_break;
`endif

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .PARITY_MODE(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_perr   (rx_perr),
    .rx_ferr   (rx_ferr),
    .rx_overrun(rx_overrun),
`ifdef UART_RX_BREAK_DET_EN
    .rx_break  (rx_break),
`endif
    .rx_busy   (rx_busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  word_t exp_q[$];
  word_t w;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int ovr_seen = 0;
  int brk_seen = 0;
  int t_start = 0;
  int t_valid = 0;
  logic valid_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // even parity: error when data plus parity bit has odd weight
  function automatic word_t model(input logic [7:0] d,
                                  input logic p,
                                  input logic s);
    word_t r;
    r.d  = d;
    r.pe = p ^ (^d);
    r.fe = !s;
    return r;
  endfunction

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic s);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = p;
    repeat (BIT) @(negedge clk);
    rx = s;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] d,
                           input logic p,
                           input logic s);
    exp_q.push_back(model(d, p, s));
    send_frame(d, p, s);
  endtask

  // consumer side: every accepted word must match the model queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_overrun) ovr_seen++;
`ifdef UART_RX_BREAK_DET_EN
      if (rx_break) brk_seen++;
`endif
      if (rx_valid && !valid_d) t_valid = cyc;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, rx_data}, 32'hFFFF);
        end else begin
          w = exp_q.pop_front();
          check("rx_data", rx_data, w.d);
          check("rx_perr", rx_perr, w.pe);
          check("rx_ferr", rx_ferr, w.fe);
        end
      end
      valid_d = rx_valid;
    end else begin
      valid_d = 1'b0;
    end
  end

  initial begin
    logic [7:0] d;
    logic p, s;
    int g, lat;

    repeat (5) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", rx_busy, 0);
    check("reset_flags", {rx_perr, rx_ferr, rx_overrun}, 0);
    rst_n = 1'b1;
    wait_bits(2);

    send_word(8'hA5, 1'b0, 1'b1);
    wait_bits(1);
    lat = t_valid - t_start;
    check("latency_window",
          (lat >= LAT_LO && lat <= LAT_HI), 1);

    send_word(8'h07, 1'b0, 1'b1);
    wait_bits(1);
    send_word(8'h07, 1'b1, 1'b1);
    wait_bits(1);

    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0) || (d == 8'h00);
      g = s ? int'($urandom_range(0, 2))
            : int'($urandom_range(1, 2));
      send_word(d, p, s);
      wait_bits(g);
    end
    wait_bits(2);
    check("random_drained", exp_q.size(), 0);

    rx_ready = 1'b0;
    exp_q.push_back(model(8'h11, 1'b0, 1'b1));
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    wait_bits(2);
    check("hold_valid", rx_valid, 1);
    check("hold_data", rx_data, 8'h11);
    check("overrun_count", ovr_seen, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid_drop", rx_valid, 0);
    check("overrun_drained", exp_q.size(), 0);

    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", rx_busy, 1);
    repeat (3 * DIV - 10) @(negedge clk);
    rx = 1'b1;
    repeat (BIT - 3 * DIV) @(negedge clk);
    check("glitch_idle", rx_busy, 0);
    wait_bits(1);

    send_word(8'h3C, 1'b0, 1'b0);
    wait_bits(2);
    check("ferr_drained", exp_q.size(), 0);
    check("ferr_data_held", rx_data, 8'h3C);

    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    d = 8'h55;
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    repeat (BIT / 2) @(negedge clk);
    check("busy_in_frame", rx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", rx_valid, 0);
    check("midreset_data", rx_data, 0);
    check("midreset_busy", rx_busy, 0);
    check("midreset_flags",
          {rx_perr, rx_ferr, rx_overrun}, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    wait_bits(2);
    send_word(8'h66, 1'b0, 1'b1);
    wait_bits(2);
    check("after_reset_drained", exp_q.size(), 0);

`ifndef UART_RX_BREAK_DET_EN
    exp_q.push_back(model(8'h00, 1'b0, 1'b0));
`endif
    @(negedge clk);
    rx = 1'b0;
    repeat (22 * BIT) @(negedge clk);
    rx = 1'b1;
    wait_bits(3);
    check("zero_frame_drained", exp_q.size(), 0);
    check("zero_frame_idle", rx_busy, 0);
`ifdef UART_RX_BREAK_DET_EN
    check("break_count", brk_seen, 1);
`endif
    check("overrun_total", ovr_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
